sipo_shift_receiver: RTL and testbench

//  Serial-in parallel-out word receiver; the receive-side counterpart of piso_shift_register.

---
 rtl/sipo_shift_receiver.sv | 95 +++++++++
 tb/tb_sipo_shift_receiver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_receiver.sv
// Serial-in parallel-out word receiver, LSB first, with valid/ready output and sticky overrun.
// Optional frame-sync input enabled by defining SIPO_FRAME_SYNC_EN.
module sipo_shift_receiver #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             in,
`ifdef SIPO_FRAME_SYNC_EN
  input  logic             sync,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // The oldest collected bit is always shifted out at word completion, so only WIDTH-1
  // bits of history are kept; the incoming bit supplies the top of the word.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             sync_hit;
  logic             complete;

`ifdef SIPO_FRAME_SYNC_EN
  assign sync_hit = enable & sync;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    shifted   = {in, shreg_q};
    complete  = enable && !sync_hit && (bit_cnt_q == CNT_W'(WIDTH - 1));
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    out_d     = out_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (enable) begin
      shreg_d = shifted[WIDTH-1:1];
      if (sync_hit) begin
        bit_cnt_d = CNT_W'(1);
      end else if (complete) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (complete) begin
      out_d   = shifted;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Set has priority over a same-cycle clear.
    if (complete && valid_q && !out_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Directed bench for sipo_shift_receiver; expected words queued when sent, popped on completion.
// Frame-sync scenarios are compiled in when SIPO_FRAME_SYNC_EN is defined.
module tb_sipo_shift_receiver;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        in = 1'b0;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic        ovr_clr = 1'b0;
`ifdef SIPO_FRAME_SYNC_EN
  logic        sync = 1'b0;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  sipo_shift_receiver #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .in        (in),
`ifdef SIPO_FRAME_SYNC_EN
    .sync      (sync),
`endif
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a whole word LSB first; with gap=1 a disabled cycle carrying the inverted bit
  // follows every enabled one. rdy_last is applied to out_ready on the final bit only.
  task automatic send_word(input logic [31:0] w, input bit gap, input logic rdy_last);
    logic rdy_body;
    rdy_body = out_ready;
    exp_q.push_back(w);
    for (int i = 0; i < 32; i++) begin
      enable    = 1'b1;
      in        = w[i];
      out_ready = (i == 31) ? rdy_last : rdy_body;
      tick();
      if (gap) begin
        enable = 1'b0;
        in     = ~w[i];
        tick();
      end
    end
    enable    = 1'b0;
    out_ready = rdy_body;
  endtask

  task automatic check_word(input string tag);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_out"}, out, exp);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_out", out, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_ovr", {31'b0, overrun}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: plain word, consumer ready
    out_ready = 1'b1;
    send_word(32'hF0F0F0F0, 1'b0, 1'b1);
    check_word("t1");
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_ovr", {31'b0, overrun}, 32'd0);
    tick();
    check("t1_valid_one_cycle", {31'b0, out_valid}, 32'd0);
    check("t1_out_held", out, 32'hF0F0F0F0);

    // 2: enable every other clock, with garbage on disabled cycles
    out_ready = 1'b0;
    send_word(32'hF0F0F0F0, 1'b1, 1'b0);
    check_word("t2");
    check("t2_valid", {31'b0, out_valid}, 32'd1);
    check("t2_ovr", {31'b0, overrun}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_consumed", {31'b0, out_valid}, 32'd0);

    // 3: unconsumed word overwritten -> overrun, then cleared
    send_word(32'hF0F0F0F0, 1'b0, 1'b0);
    check_word("t3a");
    check("t3a_ovr", {31'b0, overrun}, 32'd0);
    send_word(32'h0000000F, 1'b0, 1'b0);
    check_word("t3b");
    check("t3b_valid", {31'b0, out_valid}, 32'd1);
    check("t3b_ovr", {31'b0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t3_ovr_cleared", {31'b0, overrun}, 32'd0);
    check("t3_valid_kept", {31'b0, out_valid}, 32'd1);

    // 4: consume on the completion edge of the next word -> no overrun
    send_word(32'h12345678, 1'b0, 1'b1);
    check_word("t4");
    check("t4_valid", {31'b0, out_valid}, 32'd1);
    check("t4_ovr", {31'b0, overrun}, 32'd0);

    // Overrun set wins over a same-cycle clear
    ovr_clr = 1'b1;
    send_word(32'hCAFEBABE, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    check_word("t4b");
    check("t4b_set_wins", {31'b0, overrun}, 32'd1);

    // 5: asynchronous reset mid-word, then realigned word
    for (int i = 0; i < 10; i++) begin
      enable = 1'b1;
      in     = 1'b1;
      tick();
    end
    enable = 1'b0;
    rstn   = 1'b0;
    #1;
    check("t5_rst_out", out, 32'h0);
    check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_ovr", {31'b0, overrun}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    send_word(32'h0000000F, 1'b0, 1'b0);
    check_word("t5");
    check("t5_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_consumed", {31'b0, out_valid}, 32'd0);

    // Back-to-back words, consumer always ready
    out_ready = 1'b1;
    send_word(32'hDEADBEEF, 1'b0, 1'b1);
    check_word("b2b_a");
    send_word(32'h0BADF00D, 1'b0, 1'b1);
    check_word("b2b_b");
    check("b2b_ovr", {31'b0, overrun}, 32'd0);
    tick();
    out_ready = 1'b0;

`ifdef SIPO_FRAME_SYNC_EN
    // 6: sync at bit 17 discards the partial word
    for (int i = 0; i < 17; i++) begin
      enable = 1'b1;
      in     = 1'b1;
      tick();
    end
    exp_q.push_back(32'hA5A5A5A5);
    begin
      logic [31:0] w;
      w = 32'hA5A5A5A5;
      for (int i = 0; i < 32; i++) begin
        enable = 1'b1;
        sync   = (i == 0);
        in     = w[i];
        tick();
        if (i == 30) check("t6_no_early_word", {31'b0, out_valid}, 32'd0);
      end
      sync   = 1'b0;
      enable = 1'b0;
    end
    check_word("t6");
    check("t6_valid", {31'b0, out_valid}, 32'd1);
    check("t6_ovr", {31'b0, overrun}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Sync on the would-be completion edge suppresses the word
    for (int i = 0; i < 31; i++) begin
      enable = 1'b1;
      in     = 1'b0;
      tick();
    end
    exp_q.push_back(32'h5A5A5A5B);
    begin
      logic [31:0] w;
      w = 32'h5A5A5A5B;
      for (int i = 0; i < 32; i++) begin
        enable = 1'b1;
        sync   = (i == 0);
        in     = w[i];
        tick();
        if (i == 0) check("t6b_sync_suppress", {31'b0, out_valid}, 32'd0);
      end
      sync   = 1'b0;
      enable = 1'b0;
    end
    check_word("t6b");
    check("t6b_valid", {31'b0, out_valid}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
